// File: rtl/debug_host_engine_pkg.sv
// Shared constants for the debug UART host engine: opcodes, capture kinds,
// FSM state encodings and response-length helpers.
package debug_host_engine_pkg;

  // Command opcodes
  localparam logic [7:0] OP_WRITE_IM     = 8'd1;
  localparam logic [7:0] OP_START        = 8'd2;
  localparam logic [7:0] OP_STEP_BY_STEP = 8'd3;
  localparam logic [7:0] OP_SEND_BR      = 8'd4;
  localparam logic [7:0] OP_SEND_MEM     = 8'd5;
  localparam logic [7:0] OP_SEND_PC      = 8'd6;
  localparam logic [7:0] OP_STEP         = 8'd7;
  localparam logic [7:0] OP_CONTINUE     = 8'd8;

  // o_cap_kind encodings
  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_BR  = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;

  // FSM state encodings
  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_SEND_OP      = 4'd1;
  localparam logic [3:0] ST_WAIT_OP_TX   = 4'd2;
  localparam logic [3:0] ST_PROG_FETCH   = 4'd3;
  localparam logic [3:0] ST_PROG_LATCH   = 4'd4;
  localparam logic [3:0] ST_PROG_BYTE    = 4'd5;
  localparam logic [3:0] ST_WAIT_PROG_TX = 4'd6;
  localparam logic [3:0] ST_RECV         = 4'd7;
  localparam logic [3:0] ST_FINISH       = 4'd8;

  // Response framing
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned PC_RSP_BYTES   = 1;

  // Number of response bytes the target returns for an opcode
  function automatic int unsigned rsp_len(input logic [7:0] op, input int unsigned n_dump_words);
    case (op)
      OP_SEND_PC:              return PC_RSP_BYTES;
      OP_SEND_BR, OP_SEND_MEM: return BYTES_PER_WORD * n_dump_words;
      OP_STEP:                 return PC_RSP_BYTES + 2 * BYTES_PER_WORD * n_dump_words;
      OP_WRITE_IM, OP_START,
      OP_STEP_BY_STEP,
      OP_CONTINUE:             return 0;
      default:                 return 0;
    endcase
  endfunction

  // Opcodes 1..8 are legal
  function automatic logic is_legal_op(input logic [7:0] op);
    return (op >= OP_WRITE_IM) && (op <= OP_CONTINUE);
  endfunction

endpackage

// File: rtl/debug_word_assembler.sv
// Shifts MSB-first response bytes into words; single-byte (PC) words bypass the shifter.
module debug_word_assembler #(
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_byte_valid,
  input  logic               i_single,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic               o_word_valid,
  output logic [NB_DATA-1:0] o_word
);

  localparam int unsigned BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int unsigned NB_BCNT        = $clog2(BYTES_PER_WORD);
  localparam int unsigned NB_PART        = NB_DATA - NB_BYTE;

  logic [NB_PART-1:0] part_q, part_d;
  logic [NB_BCNT-1:0] bcnt_q, bcnt_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic               valid_q, valid_d;
  logic [NB_DATA-1:0] shifted;

  // Next partial word, byte count and completed-word output
  always_comb begin
    part_d  = part_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    shifted = {part_q, i_byte};
    if (i_clear) begin
      part_d = '0;
      bcnt_d = '0;
    end else if (i_byte_valid) begin
      if (i_single) begin
        word_d  = NB_DATA'(i_byte);
        valid_d = 1'b1;
      end else if (bcnt_q == NB_BCNT'(BYTES_PER_WORD - 1)) begin
        word_d  = shifted;
        valid_d = 1'b1;
        part_d  = '0;
        bcnt_d  = '0;
      end else begin
        part_d = shifted[NB_PART-1:0];
        bcnt_d = bcnt_q + NB_BCNT'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      part_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      part_q  <= part_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign o_word_valid = valid_q;
  assign o_word       = word_q;

endmodule

// File: rtl/debug_host_engine.sv
// Host-side master for the MIPS debug UART: sends opcodes, streams the program
// image, and collects/tag dump words returned by the target.
module debug_host_engine
  import debug_host_engine_pkg::*;
#(
  parameter int unsigned NB_BYTE        = 8,
  parameter int unsigned NB_DATA        = 32,
  parameter int unsigned IM_WORDS       = 11,
  parameter int unsigned N_DUMP_WORDS   = 32,
  parameter int unsigned NB_PROG_ADDR   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_cmd_valid,
  input  logic [7:0]              i_cmd,
  output logic                    o_cmd_ready,
  output logic [NB_PROG_ADDR-1:0] o_prog_addr,
  input  logic [NB_DATA-1:0]      i_prog_data,
  output logic                    o_tx_start,
  output logic [NB_BYTE-1:0]      o_tx_data,
  input  logic                    i_tx_done,
  input  logic                    i_rx_done,
  input  logic [NB_BYTE-1:0]      i_rx_data,
  output logic                    o_cap_valid,
  output logic [1:0]              o_cap_kind,
  output logic [4:0]              o_cap_index,
  output logic [NB_DATA-1:0]      o_cap_data,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int unsigned NB_CNT    = $clog2(2 * BYTES_PER_WORD * N_DUMP_WORDS + 2);
  localparam int unsigned NB_TO     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DUMP_BYTES = BYTES_PER_WORD * N_DUMP_WORDS;

  logic [3:0]              state_q, state_d;
  logic [7:0]              op_q, op_d;
  logic [NB_CNT-1:0]       rx_cnt_q, rx_cnt_d;
  logic [NB_TO-1:0]        to_cnt_q, to_cnt_d;
  logic [NB_PROG_ADDR-1:0] prog_addr_q, prog_addr_d;
  logic [NB_DATA-1:0]      prog_word_q, prog_word_d;
  logic [1:0]              byte_sel_q, byte_sel_d;
  logic                    tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0]      tx_data_q, tx_data_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic [1:0]              cap_kind_q, cap_kind_d;
  logic [4:0]              cap_index_q, cap_index_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [NB_CNT-1:0]       rel_c;
  logic                    is_pc_c;
  logic                    word_end_c;
  logic [1:0]              kind_c;
  logic [4:0]              index_c;
  logic                    last_byte_c;
  logic                    rx_byte_c;

  // Tag the incoming byte (kind, word index, word boundary) from the running byte count
  always_comb begin
    is_pc_c = (op_q == OP_SEND_PC) || ((op_q == OP_STEP) && (rx_cnt_q == '0));
    rel_c   = (op_q == OP_STEP) ? (rx_cnt_q - NB_CNT'(1)) : rx_cnt_q;
    kind_c  = KIND_BR;
    index_c = 5'(rel_c >> 2);
    if (is_pc_c) begin
      kind_c  = KIND_PC;
      index_c = '0;
    end else if (op_q == OP_SEND_MEM) begin
      kind_c = KIND_MEM;
    end else if ((op_q == OP_STEP) && (rel_c >= NB_CNT'(DUMP_BYTES))) begin
      kind_c  = KIND_MEM;
      index_c = 5'((rel_c - NB_CNT'(DUMP_BYTES)) >> 2);
    end
    word_end_c  = is_pc_c || (rel_c[1:0] == 2'b11);
    last_byte_c = (rx_cnt_q == NB_CNT'(rsp_len(op_q, N_DUMP_WORDS) - 32'd1));
    rx_byte_c   = (state_q == ST_RECV) && i_rx_done;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rx_cnt_d    = rx_cnt_q;
    to_cnt_d    = to_cnt_q;
    prog_addr_d = prog_addr_q;
    prog_word_d = prog_word_q;
    byte_sel_d  = byte_sel_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    cap_kind_d  = cap_kind_q;
    cap_index_d = cap_index_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          if (is_legal_op(i_cmd)) begin
            op_d    = i_cmd;
            state_d = ST_SEND_OP;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_SEND_OP: begin
        tx_start_d = 1'b1;
        tx_data_d  = NB_BYTE'(op_q);
        state_d    = ST_WAIT_OP_TX;
      end
      ST_WAIT_OP_TX: begin
        if (i_tx_done) begin
          if (op_q == OP_WRITE_IM) begin
            prog_addr_d = '0;
            state_d     = ST_PROG_FETCH;
          end else if (rsp_len(op_q, N_DUMP_WORDS) == 0) begin
            state_d = ST_FINISH;
          end else begin
            rx_cnt_d = '0;
            to_cnt_d = '0;
            state_d  = ST_RECV;
          end
        end
      end
      ST_PROG_FETCH: begin
        state_d = ST_PROG_LATCH;
      end
      ST_PROG_LATCH: begin
        prog_word_d = i_prog_data;
        byte_sel_d  = '0;
        state_d     = ST_PROG_BYTE;
      end
      ST_PROG_BYTE: begin
        tx_start_d = 1'b1;
        tx_data_d  = prog_word_q[byte_sel_q*NB_BYTE +: NB_BYTE];
        state_d    = ST_WAIT_PROG_TX;
      end
      ST_WAIT_PROG_TX: begin
        if (i_tx_done) begin
          if (byte_sel_q == 2'd3) begin
            if (prog_addr_q == NB_PROG_ADDR'(IM_WORDS - 1)) begin
              state_d = ST_FINISH;
            end else begin
              prog_addr_d = prog_addr_q + NB_PROG_ADDR'(1);
              state_d     = ST_PROG_FETCH;
            end
          end else begin
            byte_sel_d = byte_sel_q + 2'd1;
            state_d    = ST_PROG_BYTE;
          end
        end
      end
      ST_RECV: begin
        if (i_rx_done) begin
          to_cnt_d = '0;
          rx_cnt_d = rx_cnt_q + NB_CNT'(1);
          if (word_end_c) begin
            cap_kind_d  = kind_c;
            cap_index_d = index_c;
          end
          if (last_byte_c) begin
            state_d = ST_FINISH;
          end
        end else if (to_cnt_q == NB_TO'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + NB_TO'(1);
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rx_cnt_q    <= '0;
      to_cnt_q    <= '0;
      prog_addr_q <= '0;
      prog_word_q <= '0;
      byte_sel_q  <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      cmd_ready_q <= 1'b1;
      cap_kind_q  <= '0;
      cap_index_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rx_cnt_q    <= rx_cnt_d;
      to_cnt_q    <= to_cnt_d;
      prog_addr_q <= prog_addr_d;
      prog_word_q <= prog_word_d;
      byte_sel_q  <= byte_sel_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      cmd_ready_q <= cmd_ready_d;
      cap_kind_q  <= cap_kind_d;
      cap_index_q <= cap_index_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  debug_word_assembler #(
    .NB_BYTE (NB_BYTE),
    .NB_DATA (NB_DATA)
  ) u_assembler (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (state_q != ST_RECV),
    .i_byte_valid (rx_byte_c),
    .i_single     (is_pc_c),
    .i_byte       (i_rx_data),
    .o_word_valid (o_cap_valid),
    .o_word       (o_cap_data)
  );

  assign o_cmd_ready = cmd_ready_q;
  assign o_prog_addr = prog_addr_q;
  assign o_tx_start  = tx_start_q;
  assign o_tx_data   = tx_data_q;
  assign o_cap_kind  = cap_kind_q;
  assign o_cap_index = cap_index_q;
  assign o_done      = done_q;
  assign o_error     = error_q;

endmodule
